// File: rtl/ldt_link_init_ctrl.sv
// LDT link bring-up controller: decodes the CTL/CAD differential samples and sequences
// the link through OFF, ENABLE, WAIT_CTL, TRAIN and UP, dropping to FAULT on timeout or errors.
module ldt_link_init_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 16,
  parameter int SYNC_CNT  = 32,
  parameter int TIMEOUT   = 1024,
  parameter int ERR_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CTL_P,
  input  logic             CTL_N,
  input  logic [WIDTH-1:0] CAD_P,
  input  logic [WIDTH-1:0] CAD_N,
  output logic             BUF_EN,
  output logic [2:0]       STATE,
  output logic             LINK_UP,
  output logic [WIDTH-1:0] CAD_O,
  output logic             CTL_O,
  output logic             CAD_VLD,
  output logic [7:0]       ERR_CNT,
  output logic             PAIR_ERR
);

  // Counters only need to reach limit-1; the transition fires on that value.
  localparam int SETTLE_W = (SETTLE > 1)    ? $clog2(SETTLE)    : 1;
  localparam int RUN_W    = (SYNC_CNT > 1)  ? $clog2(SYNC_CNT)  : 1;
  localparam int TMO_W    = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;
  localparam int ERR_W    = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_ENABLE   = 3'd1,
    S_WAIT_CTL = 3'd2,
    S_TRAIN    = 3'd3,
    S_UP       = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [SETTLE_W-1:0]  settle_cnt_reg;
  logic [RUN_W-1:0]     run_cnt_reg;
  logic [TMO_W-1:0]     tmo_cnt_reg;
  logic [ERR_W-1:0]     err_run_reg;
  logic [WIDTH-1:0]     cad_reg;
  logic [WIDTH-1:0]     cad_next;
  logic [WIDTH-1:0]     cad_valid;
  logic                 ctl_reg;
  logic                 ctl_next;
  logic                 ctl_ok;
  logic                 cad_ok;
  logic                 all_ok;
  logic                 sync_hit;
  logic                 train_hit;
  logic                 tmo_hit;

  // An invalid pair (P == N) keeps the last decoded bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair
      assign cad_valid[gi] = CAD_P[gi] ^ CAD_N[gi];
      assign cad_next[gi]  = cad_valid[gi] ? CAD_P[gi] : cad_reg[gi];
    end
  endgenerate

  assign ctl_ok    = CTL_P ^ CTL_N;
  assign ctl_next  = ctl_ok ? CTL_P : ctl_reg;
  assign cad_ok    = &cad_valid;
  assign all_ok    = cad_ok & ctl_ok;
  assign sync_hit  = all_ok & CTL_P;
  assign train_hit = all_ok & ~CTL_P;
  assign tmo_hit   = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));

  assign STATE = state_reg;
  assign CAD_O = cad_reg;
  assign CTL_O = ctl_reg;

  always_comb begin
    state_next = state_reg;
    if (!EN) begin
      state_next = S_OFF;
    end else begin
      case (state_reg)
        S_OFF:      state_next = S_ENABLE;
        S_ENABLE:   if (settle_cnt_reg == SETTLE_W'(SETTLE - 1)) state_next = S_WAIT_CTL;
        S_WAIT_CTL: begin
          if (sync_hit && (run_cnt_reg == RUN_W'(SYNC_CNT - 1))) state_next = S_TRAIN;
          else if (tmo_hit)                                    state_next = S_FAULT;
        end
        S_TRAIN: begin
          if (train_hit)    state_next = S_UP;
          else if (tmo_hit) state_next = S_FAULT;
        end
        S_UP:       if (!all_ok && (err_run_reg == ERR_W'(ERR_LIMIT - 1))) state_next = S_FAULT;
        S_FAULT:    state_next = S_FAULT;
        default:    state_next = S_OFF;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg      <= S_OFF;
      BUF_EN         <= 1'b0;
      LINK_UP        <= 1'b0;
      CAD_VLD        <= 1'b0;
      cad_reg        <= '0;
      ctl_reg        <= 1'b0;
      ERR_CNT        <= 8'd0;
      PAIR_ERR       <= 1'b0;
      settle_cnt_reg <= '0;
      run_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      err_run_reg    <= '0;
    end else begin
      state_reg <= state_next;
      BUF_EN    <= (state_next != S_OFF);
      LINK_UP   <= (state_next == S_UP);
      CAD_VLD   <= (state_next == S_UP) && all_ok;
      cad_reg   <= cad_next;
      ctl_reg   <= ctl_next;
      // Counter updates are suppressed while EN is low; the link just drops to OFF.
      if (EN) begin
        case (state_reg)
          S_OFF: begin
            settle_cnt_reg <= '0;
            err_run_reg    <= '0;
            ERR_CNT        <= 8'd0;
            PAIR_ERR       <= 1'b0;
          end
          S_ENABLE: begin
            settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
            run_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
          end
          S_WAIT_CTL: begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            run_cnt_reg <= sync_hit ? run_cnt_reg + RUN_W'(1) : '0;
          end
          S_TRAIN: begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            err_run_reg <= '0;
          end
          S_UP: begin
            if (all_ok) begin
              err_run_reg <= '0;
            end else begin
              err_run_reg <= err_run_reg + ERR_W'(1);
              PAIR_ERR    <= 1'b1;
              if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldt_link_init_ctrl.sv
// Scoreboard bench for ldt_link_init_ctrl: directed bring-up/fault scenarios plus random
// segments, every cycle checked against a cycle-count reference model of the link rules.
module tb_ldt_link_init_ctrl;

  localparam int W       = 8;
  localparam int SETTLE  = 16;
  localparam int SYNC    = 32;
  localparam int TIMEOUT = 1024;
  localparam int ELIM    = 4;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         EN = 1'b0;
  logic         CTL_P = 1'b0;
  logic         CTL_N = 1'b0;
  logic [W-1:0] CAD_P = '0;
  logic [W-1:0] CAD_N = '0;
  logic         BUF_EN;
  logic [2:0]   STATE;
  logic         LINK_UP;
  logic [W-1:0] CAD_O;
  logic         CTL_O;
  logic         CAD_VLD;
  logic [7:0]   ERR_CNT;
  logic         PAIR_ERR;

  ldt_link_init_ctrl #(
    .WIDTH(W), .SETTLE(SETTLE), .SYNC_CNT(SYNC), .TIMEOUT(TIMEOUT), .ERR_LIMIT(ELIM)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CTL_P(CTL_P), .CTL_N(CTL_N),
    .CAD_P(CAD_P), .CAD_N(CAD_N), .BUF_EN(BUF_EN), .STATE(STATE), .LINK_UP(LINK_UP),
    .CAD_O(CAD_O), .CTL_O(CTL_O), .CAD_VLD(CAD_VLD), .ERR_CNT(ERR_CNT), .PAIR_ERR(PAIR_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         bufen;
    logic [2:0]   st;
    logic         linkup;
    logic [W-1:0] cad;
    logic         ctl;
    logic         vld;
    logic [7:0]   errcnt;
    logic         perr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;
  int pop_idx = 0;
  int rise_idx = -1;
  int en_idx = 0;

  // Reference model: state number plus "how long / how many" counts taken straight from the rules.
  int           m_st = 0;
  int           m_time = 0;
  int           m_run = 0;
  int           m_errrun = 0;
  int           m_errcnt = 0;
  logic         m_perr = 0;
  logic [W-1:0] m_cad = '0;
  logic         m_ctl = 0;
  logic         m_bufen = 0;
  logic         m_linkup = 0;
  logic         m_vld = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic cp, input logic cn,
                            input logic [W-1:0] dp, input logic [W-1:0] dn);
    logic cad_ok;
    logic ctl_ok;
    logic ok;
    int   nxt;
    cad_ok = 1'b1;
    for (int i = 0; i < W; i++) if (dp[i] == dn[i]) cad_ok = 1'b0;
    ctl_ok = (cp != cn);
    ok = cad_ok && ctl_ok;
    if (!rst) begin
      m_st = 0; m_time = 0; m_run = 0; m_errrun = 0; m_errcnt = 0; m_perr = 0;
      m_cad = '0; m_ctl = 0; m_bufen = 0; m_linkup = 0; m_vld = 0;
      return;
    end
    for (int i = 0; i < W; i++) if (dp[i] != dn[i]) m_cad[i] = dp[i];
    if (ctl_ok) m_ctl = cp;
    nxt = m_st;
    if (!en) begin
      nxt = 0;
    end else begin
      case (m_st)
        0: begin nxt = 1; m_time = 0; m_errcnt = 0; m_perr = 0; m_errrun = 0; end
        1: begin
          m_time++;
          if (m_time == SETTLE) begin nxt = 2; m_time = 0; m_run = 0; end
        end
        2: begin
          m_time++;
          m_run = (ok && cp) ? m_run + 1 : 0;
          if (m_run == SYNC) nxt = 3;
          else if (m_time == TIMEOUT) nxt = 5;
        end
        3: begin
          m_time++;
          if (ok && !cp) begin nxt = 4; m_errrun = 0; end
          else if (m_time == TIMEOUT) nxt = 5;
        end
        4: begin
          if (ok) m_errrun = 0;
          else begin
            m_perr = 1;
            if (m_errcnt < 255) m_errcnt++;
            m_errrun++;
            if (m_errrun == ELIM) nxt = 5;
          end
        end
        5: nxt = 5;
        default: nxt = 0;
      endcase
    end
    m_st = nxt;
    m_bufen = (nxt != 0);
    m_linkup = (nxt == 4);
    m_vld = (nxt == 4) && ok;
  endtask

  task automatic drive(input logic rst, input logic en, input logic cp, input logic cn,
                       input logic [W-1:0] dp, input logic [W-1:0] dn);
    exp_t e;
    @(negedge CLK);
    RST_N = rst; EN = en; CTL_P = cp; CTL_N = cn; CAD_P = dp; CAD_N = dn;
    model_step(rst, en, cp, cn, dp, dn);
    e.bufen = m_bufen; e.st = 3'(m_st); e.linkup = m_linkup; e.cad = m_cad;
    e.ctl = m_ctl; e.vld = m_vld; e.errcnt = 8'(m_errcnt); e.perr = m_perr;
    sb.push_back(e);
    txn++;
  endtask

  task automatic good(input logic en, input logic ctl, input logic [W-1:0] d);
    drive(1'b1, en, ctl, ~ctl, d, ~d);
  endtask

  // One invalid pair: either a CAD bit with P == N or the CTL pair with P == N.
  task automatic bad();
    logic [W-1:0] d;
    logic [W-1:0] dn;
    logic c;
    int k;
    d = W'($urandom);
    dn = ~d;
    c = 1'($urandom);
    k = $urandom_range(0, W - 1);
    if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b1, c, c, d, dn);
    else begin
      dn[k] = d[k];
      drive(1'b1, 1'b1, c, ~c, d, dn);
    end
  endtask

  task automatic go_off();
    good(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic bring_up();
    for (int i = 0; i < 1 + SETTLE + SYNC; i++) good(1'b1, 1'b1, 8'hA5);
    good(1'b1, 1'b0, W'($urandom));
  endtask

  task automatic settle_point();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    logic mism;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        mism = (BUF_EN !== e.bufen) || (STATE !== e.st) || (LINK_UP !== e.linkup) ||
               (CAD_O !== e.cad) || (CTL_O !== e.ctl) || (CAD_VLD !== e.vld) ||
               (ERR_CNT !== e.errcnt) || (PAIR_ERR !== e.perr);
        checks++;
        if (mism) begin
          failures++;
          $display("FAIL txn%0d actual st=%0d buf=%0b up=%0b cad=%h ctl=%0b vld=%0b err=%0d perr=%0b required st=%0d buf=%0b up=%0b cad=%h ctl=%0b vld=%0b err=%0d perr=%0b",
                   pop_idx, STATE, BUF_EN, LINK_UP, CAD_O, CTL_O, CAD_VLD, ERR_CNT, PAIR_ERR,
                   e.st, e.bufen, e.linkup, e.cad, e.ctl, e.vld, e.errcnt, e.perr);
        end else begin
          $display("txn%0d st=%0d buf=%0b up=%0b cad=%h vld=%0b err=%0d perr=%0b",
                   pop_idx, STATE, BUF_EN, LINK_UP, CAD_O, CAD_VLD, ERR_CNT, PAIR_ERR);
        end
        if (LINK_UP === 1'b1 && rise_idx < 0) rise_idx = pop_idx;
        pop_idx++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] dn;
    int mode;
    int len;

    // Reset with arbitrary inputs, EN high included.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
    settle_point();
    chk("reset_state", int'(STATE), 0);
    chk("reset_bufen", int'(BUF_EN), 0);
    go_off();

    // Clean bring-up: LINK_UP 16+32+1 edges after EN is sampled.
    en_idx = txn;
    bring_up();
    settle_point();
    chk("bringup_state", int'(STATE), 4);
    chk("linkup_latency", rise_idx - en_idx, 1 + SETTLE + SYNC);
    for (int i = 0; i < 20; i++) good(1'b1, 1'($urandom), W'($urandom));

    // Error bursts in UP: 3 bad, 1 good, 3 bad stays UP; a 4th consecutive bad faults.
    for (int i = 0; i < 3; i++) bad();
    good(1'b1, 1'b1, W'($urandom));
    for (int i = 0; i < 3; i++) bad();
    settle_point();
    chk("burst_state", int'(STATE), 4);
    chk("burst_errcnt", int'(ERR_CNT), 6);
    chk("burst_perr", int'(PAIR_ERR), 1);
    bad();
    settle_point();
    chk("burst_fault", int'(STATE), 5);
    for (int i = 0; i < 5; i++) good(1'b1, 1'b1, W'($urandom));
    settle_point();
    chk("fault_hold", int'(STATE), 5);
    chk("fault_bufen", int'(BUF_EN), 1);
    go_off();
    settle_point();
    chk("fault_off", int'(STATE), 0);
    chk("errcnt_persist", int'(ERR_CNT), 7);

    // Single P == N CAD bit in UP: the bit holds, CAD_VLD drops.
    bring_up();
    good(1'b1, 1'b0, 8'h3C);
    d = 8'hC3;
    dn = ~d;
    dn[2] = d[2];
    drive(1'b1, 1'b1, 1'b0, 1'b1, d, dn);
    settle_point();
    chk("hold_cad", int'(CAD_O), 8'hC7);
    chk("hold_vld", int'(CAD_VLD), 0);
    go_off();

    // Run counter restart in WAIT_CTL.
    for (int i = 0; i < 1 + SETTLE; i++) good(1'b1, 1'b1, W'($urandom));
    for (int i = 0; i < SYNC - 2; i++) good(1'b1, 1'b1, W'($urandom));
    d = W'($urandom);
    dn = ~d;
    dn[5] = d[5];
    drive(1'b1, 1'b1, 1'b1, 1'b0, d, dn);
    for (int i = 0; i < SYNC - 1; i++) good(1'b1, 1'b1, W'($urandom));
    settle_point();
    chk("restart_wait", int'(STATE), 2);
    good(1'b1, 1'b1, W'($urandom));
    settle_point();
    chk("restart_train", int'(STATE), 3);
    good(1'b1, 1'b0, W'($urandom));
    go_off();

    // CTL stuck invalid: FAULT exactly at the timeout.
    for (int i = 0; i < 1 + SETTLE + TIMEOUT - 1; i++) begin
      d = W'($urandom);
      drive(1'b1, 1'b1, 1'b1, 1'b1, d, ~d);
    end
    settle_point();
    chk("tmo_before", int'(STATE), 2);
    d = W'($urandom);
    drive(1'b1, 1'b1, 1'b1, 1'b1, d, ~d);
    settle_point();
    chk("tmo_fault", int'(STATE), 5);
    chk("tmo_bufen", int'(BUF_EN), 1);
    go_off();
    settle_point();
    chk("tmo_off", int'(STATE), 0);
    chk("tmo_off_bufen", int'(BUF_EN), 0);

    // Reset from UP with ERR_CNT = 9.
    bring_up();
    for (int i = 0; i < 9; i++) begin
      bad();
      good(1'b1, 1'b1, W'($urandom));
    end
    settle_point();
    chk("pre_rst_errcnt", int'(ERR_CNT), 9);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    settle_point();
    chk("rst_state", int'(STATE), 0);
    chk("rst_errcnt", int'(ERR_CNT), 0);
    chk("rst_cad", int'(CAD_O), 0);
    chk("rst_misc", int'({BUF_EN, LINK_UP, CTL_O, CAD_VLD, PAIR_ERR}), 0);

    // Random segments: clean CTL-high, clean CTL-low, noisy, rare EN drop or reset.
    for (int s = 0; s < 120; s++) begin
      mode = $urandom_range(0, 9);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        d = W'($urandom);
        if (mode <= 3) good(1'b1, 1'b1, d);
        else if (mode <= 6) good(1'b1, 1'b0, d);
        else if (mode == 7) begin
          if ($urandom_range(0, 2) == 0) bad(); else good(1'b1, 1'($urandom), d);
        end else if (mode == 8) good(1'($urandom_range(0, 3) != 0), 1'($urandom), d);
        else drive(1'($urandom_range(0, 7) != 0), 1'b1, 1'($urandom), 1'($urandom), d, W'($urandom));
      end
    end

    settle_point();
    settle_point();
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldt_link_init_ctrl.md
LDT_LINK_INIT_CTRL -- requirements
Module: ldt_link_init_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of CAD differential pairs.
REQ-002 Parameter SETTLE, default 16: cycles spent in ENABLE after receiver enable before CTL monitoring starts.
REQ-003 Parameter SYNC_CNT, default 32: consecutive valid CTL-high cycles required to leave WAIT_CTL.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles spent in WAIT_CTL or TRAIN before FAULT.
REQ-005 Parameter ERR_LIMIT, default 4: consecutive invalid-CAD cycles in UP that force FAULT.
REQ-006 CLK  input  1  sole clock; all logic on rising edge.
REQ-007 RST_N  input  1  synchronous, active-low reset.
REQ-008 EN  input  1  link enable; low forces OFF.
REQ-009 CTL_P, CTL_N  input  1 each  true/complement sample of the CTL pair.
REQ-010 CAD_P, CAD_N  input  WIDTH each  true/complement samples of the CAD pairs.
REQ-011 BUF_EN  output  1  enable for the differential receivers.
REQ-012 STATE  output  3  current state encoding.
REQ-013 LINK_UP  output  1  high only in UP.
REQ-014 CAD_O  output  WIDTH  decoded CAD data.
REQ-015 CTL_O  output  1  decoded CTL.
REQ-016 CAD_VLD  output  1  CAD_O/CTL_O qualified this cycle.
REQ-017 ERR_CNT  output  8  saturating count of invalid-pair cycles seen in UP.
REQ-018 PAIR_ERR  output  1  sticky flag: any invalid pair seen in UP.

Function
REQ-019 A pair is valid when P differs from N, with decoded value equal to P; a pair with P equal to N is invalid and its decoded bit holds its previous value.
REQ-020 Pair decode is registered: CAD_O and CTL_O reflect the samples from the previous cycle.
REQ-021 CADOK is high in a cycle when all WIDTH CAD pairs are valid; CTLOK is high when the CTL pair is valid.
REQ-022 States are OFF=0, ENABLE=1, WAIT_CTL=2, TRAIN=3, UP=4, FAULT=5; encodings 6 and 7 go to OFF on the next cycle.
REQ-023 OFF: BUF_EN=0; if EN=1, go to ENABLE and clear the cycle counter.
REQ-024 ENABLE: BUF_EN=1; after SETTLE cycles, go to WAIT_CTL and clear the counters.
REQ-025 WAIT_CTL: the run counter increments on cycles with CTLOK, CTL=1 and CADOK, and clears on any other cycle; reaching SYNC_CNT goes to TRAIN.
REQ-026 TRAIN: the first cycle with CTLOK, CTL=0 and CADOK goes to UP.
REQ-027 WAIT_CTL and TRAIN share one timeout counter, cleared on entry to WAIT_CTL; reaching TIMEOUT before the exit condition goes to FAULT.
REQ-028 UP: LINK_UP=1 and CAD_VLD=1 on every cycle with CADOK and CTLOK.
REQ-029 UP: a cycle without CADOK or CTLOK sets PAIR_ERR, increments ERR_CNT (saturating at 255) and increments a consecutive-error counter; any fully valid cycle clears that counter.
REQ-030 UP: the consecutive-error counter reaching ERR_LIMIT goes to FAULT.
REQ-031 FAULT: BUF_EN=1, LINK_UP=0 and CAD_VLD=0; the block remains in FAULT until EN=0.
REQ-032 EN=0 in any state goes to OFF on the next edge; EN takes priority over every other transition.
REQ-033 ERR_CNT and PAIR_ERR clear on entry to ENABLE and otherwise persist across FAULT and OFF.
REQ-034 LINK_UP and CAD_VLD are registered outputs derived from the next state and the current sample, with no combinational path from input to output.

Reset
REQ-035 RST_N=0 at an edge forces STATE=OFF, BUF_EN=0, LINK_UP=0, CAD_VLD=0, CAD_O=0, CTL_O=0, ERR_CNT=0, PAIR_ERR=0 and clears all counters.
REQ-036 Reset overrides EN and applies mid-operation, including from UP and FAULT.

Verification
REQ-037 EN=1, CTL valid high with CAD=8'hA5 valid for 32 cycles, then CTL low -> STATE passes 1,2,3,4; LINK_UP rises exactly 16+32+1 cycles plus pipeline after EN.
REQ-038 EN=1 with CTL_P=CTL_N=1 throughout -> FAULT after 1024 cycles in WAIT_CTL; BUF_EN stays 1; EN=0 -> OFF on the next cycle.
REQ-039 In UP, inject 3 invalid cycles, 1 valid cycle, then 3 invalid cycles -> remains UP with ERR_CNT=6 and PAIR_ERR=1; a 4th consecutive invalid cycle -> FAULT.
REQ-040 In WAIT_CTL, a single invalid CAD pair at cycle 31 -> run counter restarts; TRAIN is entered only after 32 further clean cycles.
REQ-041 In UP, a CAD bit with P=N -> CAD_O bit holds its prior value, CAD_VLD=0 for that cycle.
REQ-042 RST_N=0 for one cycle while in UP with ERR_CNT=9 -> all outputs take their REQ-035 reset values on the following cycle.
